// File: rtl/prescaled_counter.sv
// prescaled_counter: single-clock prescaler producing a step strobe that
// drives an up/down counter with programmable terminal value, synchronous
// load, and free-run (wrap) or one-shot (stop and flag) behaviour.
module prescaled_counter #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             done
);

    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [PRE_W-1:0] pre_cnt;
    logic             at_term;

    // Step strobe; >= lets a reduced div take effect without wrapping pre_cnt.
    always_comb begin
        tick    = !rst && en && (pre_cnt >= div) && !load && !done;
        at_term = up ? (q >= max_val) : (q == '0);
    end

    // Prescaler: restarts on load or step, freezes while disabled or done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (load) begin
            pre_cnt <= '0;
        end else if (en && !done) begin
            if (pre_cnt >= div)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + PRE_ONE;
        end
    end

    // Counter, terminal-count pulse and sticky one-shot flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (tick) begin
            tc <= at_term;
            if (at_term) begin
                if (oneshot)
                    done <= 1'b1;
                else
                    q <= up ? '0 : max_val;
            end else begin
                q <= up ? (q + CNT_ONE) : (q - CNT_ONE);
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prescaled_counter.sv
// Bench for prescaled_counter: a behavioural reference model predicts the
// outputs for every clock; predictions are queued at drive time and popped
// after the edge. Directed checks cover the listed scenarios.
module tb_prescaled_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, oneshot, load;
    logic [3:0] div, load_val, max_val;
    logic [3:0] q;
    logic       tick, tc, done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       done;
    } exp_t;
    exp_t sb[$];

    int m_pre, m_q;
    bit m_tc, m_done;
    int tick_cnt, tc_cnt;

    prescaled_counter #(.WIDTH(4), .PRE_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .up(up), .oneshot(oneshot),
        .load(load), .load_val(load_val), .max_val(max_val),
        .q(q), .tick(tick), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_q = 0; m_tc = 0; m_done = 0;
        sb.delete();
    endtask

    // One clock: inputs are already driven (just after negedge).
    task automatic cyc();
        bit   exp_tick, term;
        exp_t e, got;
        #1;
        exp_tick = en && (m_pre >= int'(div)) && !load && !m_done;
        chk("tick", int'(tick), int'(exp_tick));
        if (tick) tick_cnt++;
        if (load) begin
            m_q = int'(load_val); m_pre = 0; m_done = 0; m_tc = 0;
        end else if (en && !m_done) begin
            m_tc = 0;
            if (m_pre >= int'(div)) begin
                m_pre = 0;
                term = up ? (m_q >= int'(max_val)) : (m_q == 0);
                if (term) begin
                    m_tc = 1;
                    if (oneshot) m_done = 1;
                    else m_q = up ? 0 : int'(max_val);
                end else begin
                    m_q = up ? (m_q + 1) % 16 : (m_q + 15) % 16;
                end
            end else begin
                m_pre = (m_pre + 1) % 16;
            end
        end else begin
            m_tc = 0;
        end
        e.q = 4'(m_q); e.tc = m_tc; e.done = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got.q = q; got.tc = tc; got.done = done;
            e = sb.pop_front();
            chk("q", int'(got.q), int'(e.q));
            chk("tc", int'(got.tc), int'(e.tc));
            chk("done", int'(got.done), int'(e.done));
        end
        if (tc) tc_cnt++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst = 1; en = 1; up = 1; oneshot = 0; load = 0;
        div = 0; load_val = 0; max_val = 0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);

        // 1: free-run up, div=3, max=9 -> 10 steps, one wrap, period 40
        rst = 0; div = 3; max_val = 9;
        tick_cnt = 0; tc_cnt = 0;
        run(3);
        chk("t1_no_early_step", int'(q), 0);
        run(33);
        chk("t1_q_at_36", int'(q), 9);
        run(4);
        chk("t1_q_wrap", int'(q), 0);
        chk("t1_tc_after_wrap", int'(tc), 1);
        chk("t1_tick_count", tick_cnt, 10);
        chk("t1_tc_count", tc_cnt, 1);
        run(1);
        chk("t1_tc_one_cycle", int'(tc), 0);

        // 2: load 2, count down wrapping to max_val=5
        div = 0; up = 0; max_val = 5; load = 1; load_val = 2;
        cyc();
        chk("t2_load", int'(q), 2);
        load = 0;
        cyc(); chk("t2_s1", int'(q), 1);
        cyc(); chk("t2_s0", int'(q), 0);
        cyc(); chk("t2_s5", int'(q), 5); chk("t2_tc", int'(tc), 1);
        cyc(); chk("t2_s4", int'(q), 4); chk("t2_tc_clr", int'(tc), 0);

        // 3: one-shot up to 3, stays there, reload clears done
        up = 1; oneshot = 1; max_val = 3; load = 1; load_val = 0;
        cyc();
        load = 0;
        run(3);
        chk("t3_q3", int'(q), 3); chk("t3_not_done", int'(done), 0);
        cyc();
        chk("t3_done", int'(done), 1); chk("t3_tc", int'(tc), 1);
        chk("t3_q_hold", int'(q), 3);
        oneshot = 0;
        tc_cnt = 0;
        run(20);
        chk("t3_q_20", int'(q), 3); chk("t3_done_sticky", int'(done), 1);
        chk("t3_no_tc", tc_cnt, 0);
        load = 1; load_val = 0;
        cyc();
        chk("t3_done_clr", int'(done), 0);
        load = 0;
        cyc();
        chk("t3_resume", int'(q), 1);

        // 4: load on a cycle that would otherwise step
        max_val = 9; div = 2;
        load = 1; load_val = 0; cyc(); load = 0;
        run(2);
        chk("t4_pre_full", int'(dut.pre_cnt), 2);
        load = 1; load_val = 7;
        cyc();
        load = 0;
        chk("t4_q7", int'(q), 7); chk("t4_tc", int'(tc), 0);
        chk("t4_pre0", int'(dut.pre_cnt), 0);

        // 5: shrink div mid-run below pre_cnt
        div = 15; max_val = 15; load = 1; load_val = 0; cyc(); load = 0;
        run(10);
        chk("t5_pre10", int'(dut.pre_cnt), 10);
        div = 2;
        tick_cnt = 0;
        cyc();
        chk("t5_immediate", int'(q), 1);
        run(3);
        chk("t5_next", int'(q), 2);
        run(3);
        chk("t5_period3", int'(q), 3); chk("t5_ticks", tick_cnt, 3);

        // 6: async reset mid-count
        div = 3; load = 1; load_val = 6; cyc(); load = 0;
        run(2);
        chk("t6_q6", int'(q), 6);
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("t6_rst_q", int'(q), 0); chk("t6_rst_tc", int'(tc), 0);
        chk("t6_rst_pre", int'(dut.pre_cnt), 0);
        chk("t6_rst_tick", int'(tick), 0);
        model_reset();
        @(negedge clk);
        rst = 0; en = 0;
        run(5);
        chk("t6_hold", int'(q), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
